// File: rtl/jt51_timer_regs.sv
// Host-side timer register file for the JT51: address/data write port, timer
// start values, control bits, status byte and CSM key-on. JT51_TIMER_REGS_BUSY_EN adds the write-busy counter.
module jt51_timer_regs (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       cs_n,
    input  logic       wr_n,
    input  logic       a0,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       flag_A,
    input  logic       flag_B,
    input  logic       overflow_A,
    output logic [9:0] value_A,
    output logic [7:0] value_B,
    output logic       load_A,
    output logic       load_B,
    output logic       enable_irq_A,
    output logic       enable_irq_B,
    output logic       clr_flag_A,
    output logic       clr_flag_B,
    output logic       csm_keyon,
    output logic       busy
);

    logic [7:0] addr;
    logic       csm_en;
    logic       wr_last;
    logic       ov_last;
    logic       wr_cond;
    logic       write;

    // A strobe held low for many cycles must produce a single write.
    assign wr_cond = !cs_n && !wr_n;
    assign write   = wr_cond && !wr_last;

    always_ff @(posedge clk, posedge rst) begin
        if (rst) begin
            addr         <= 8'd0;
            value_A      <= 10'd0;
            value_B      <= 8'd0;
            load_A       <= 1'b0;
            load_B       <= 1'b0;
            enable_irq_A <= 1'b0;
            enable_irq_B <= 1'b0;
            csm_en       <= 1'b0;
            clr_flag_A   <= 1'b0;
            clr_flag_B   <= 1'b0;
            csm_keyon    <= 1'b0;
            wr_last      <= 1'b0;
            ov_last      <= 1'b0;
        end else begin
            wr_last    <= wr_cond;
            ov_last    <= overflow_A;
            clr_flag_A <= 1'b0;
            clr_flag_B <= 1'b0;
            // csm_en here is the pre-write value when a write lands on the same edge
            csm_keyon  <= overflow_A && !ov_last && csm_en;
            if (write) begin
                if (!a0) begin
                    addr <= din;
                end else begin
                    case (addr)
                        8'h10: value_A[9:2] <= din;
                        8'h11: value_A[1:0] <= din[1:0];
                        8'h12: value_B      <= din;
                        8'h14: begin
                            load_A       <= din[0];
                            load_B       <= din[1];
                            enable_irq_A <= din[2];
                            enable_irq_B <= din[3];
                            clr_flag_A   <= din[4];
                            clr_flag_B   <= din[5];
                            csm_en       <= din[7];
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

`ifdef JT51_TIMER_REGS_BUSY_EN
    logic [4:0] busy_cnt;

    // busy stays high for 32 cen ticks after the most recent data write
    always_ff @(posedge clk, posedge rst) begin
        if (rst) begin
            busy     <= 1'b0;
            busy_cnt <= 5'd0;
        end else if (write && a0) begin
            busy     <= 1'b1;
            busy_cnt <= 5'd31;
        end else if (busy && cen) begin
            if (busy_cnt == 5'd0) busy <= 1'b0;
            else                  busy_cnt <= busy_cnt - 5'd1;
        end
    end
`else
    assign busy = 1'b0;
`endif

    always_ff @(posedge clk, posedge rst) begin
        if (rst) dout <= 8'd0;
        else     dout <= {busy, 5'b0, flag_B, flag_A};
    end

endmodule

// File: tb/tb_jt51_timer_regs.sv
// Directed bench for jt51_timer_regs; busy-counter checks follow JT51_TIMER_REGS_BUSY_EN.
module tb_jt51_timer_regs;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cen = 1'b1;
    logic       cs_n = 1'b1;
    logic       wr_n = 1'b1;
    logic       a0 = 1'b0;
    logic [7:0] din = 8'd0;
    logic [7:0] dout;
    logic       flag_A = 1'b0;
    logic       flag_B = 1'b0;
    logic       overflow_A = 1'b0;
    logic [9:0] value_A;
    logic [7:0] value_B;
    logic       load_A, load_B, enable_irq_A, enable_irq_B;
    logic       clr_flag_A, clr_flag_B, csm_keyon, busy;

    int tests = 0;
    int fails = 0;

    jt51_timer_regs dut (
        .clk(clk), .rst(rst), .cen(cen), .cs_n(cs_n), .wr_n(wr_n), .a0(a0),
        .din(din), .dout(dout), .flag_A(flag_A), .flag_B(flag_B),
        .overflow_A(overflow_A), .value_A(value_A), .value_B(value_B),
        .load_A(load_A), .load_B(load_B), .enable_irq_A(enable_irq_A),
        .enable_irq_B(enable_irq_B), .clr_flag_A(clr_flag_A),
        .clr_flag_B(clr_flag_B), .csm_keyon(csm_keyon), .busy(busy)
    );

    always #5 clk = ~clk;

    // Called at a negedge; returns at a negedge with the strobe released for one edge.
    task automatic wr(input logic a, input logic [7:0] d);
        cs_n = 1'b0; wr_n = 1'b0; a0 = a; din = d;
        @(posedge clk); @(negedge clk);
        cs_n = 1'b1; wr_n = 1'b1;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic test_reset;
        #1;
        tests++;
        if ({value_A, value_B, load_A, load_B, enable_irq_A, enable_irq_B,
             clr_flag_A, clr_flag_B, csm_keyon, busy, dout} !== 34'd0) begin
            fails++;
            $display("FAIL reset_state: outputs=%h required 0", {value_A, value_B, dout});
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_value_regs;
        wr(0, 8'h10); wr(1, 8'hAB);
        tests++;
        if (value_A !== 10'h2AC) begin
            fails++; $display("FAIL value_A_hi: got %h required 2ac", value_A);
        end
        wr(0, 8'h11); wr(1, 8'h03);
        tests++;
        if (value_A !== 10'h2AF) begin
            fails++; $display("FAIL value_A_full: got %h required 2af", value_A);
        end
        tests++;
        if (value_B !== 8'h00) begin
            fails++; $display("FAIL value_B_untouched: got %h required 00", value_B);
        end
        wr(0, 8'h12); wr(1, 8'h5C);
        tests++;
        if (value_B !== 8'h5C || value_A !== 10'h2AF) begin
            fails++; $display("FAIL value_B: got %h/%h required 5c/2af", value_B, value_A);
        end
        // unmapped address: nothing visible changes
        wr(0, 8'h13); wr(1, 8'hFF);
        tests++;
        if (value_B !== 8'h5C || value_A !== 10'h2AF || load_A !== 1'b0) begin
            fails++; $display("FAIL unmapped_addr: got %h/%h/%b", value_B, value_A, load_A);
        end
    endtask

    task automatic test_control;
        wr(0, 8'h14);
        cs_n = 1'b0; wr_n = 1'b0; a0 = 1'b1; din = 8'h35;
        @(posedge clk); @(negedge clk);
        cs_n = 1'b1; wr_n = 1'b1;
        tests++;
        if ({load_A, load_B, enable_irq_A, enable_irq_B} !== 4'b1010) begin
            fails++;
            $display("FAIL ctrl_bits: got %b required 1010",
                     {load_A, load_B, enable_irq_A, enable_irq_B});
        end
        tests++;
        if ({clr_flag_A, clr_flag_B} !== 2'b11) begin
            fails++; $display("FAIL clr_pulse_start: got %b required 11", {clr_flag_A, clr_flag_B});
        end
        @(posedge clk); @(negedge clk);
        tests++;
        if ({clr_flag_A, clr_flag_B} !== 2'b00) begin
            fails++; $display("FAIL clr_pulse_width: got %b required 00", {clr_flag_A, clr_flag_B});
        end
        tests++;
        if (load_A !== 1'b1 || enable_irq_A !== 1'b1) begin
            fails++; $display("FAIL ctrl_hold: got %b%b required 11", load_A, enable_irq_A);
        end
    endtask

    task automatic test_dout;
        idle(40);
        flag_A = 1'b1; flag_B = 1'b0; a0 = 1'b0; cs_n = 1'b0;
        @(posedge clk); @(negedge clk);
        tests++;
        if (dout !== 8'h01) begin
            fails++; $display("FAIL dout_flagA: got %h required 01", dout);
        end
        flag_A = 1'b1; flag_B = 1'b1; a0 = 1'b1; cs_n = 1'b1;
        @(posedge clk); @(negedge clk);
        tests++;
        if (dout !== 8'h03) begin
            fails++; $display("FAIL dout_flags: got %h required 03", dout);
        end
        flag_A = 1'b0; flag_B = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    // Data write on sample 0, optional second write on sample 10.
    task automatic busy_run(input bit second, output int busy_n, output int dout7_n,
                            output int first_clr);
        busy_n = 0; dout7_n = 0; first_clr = -1;
        for (int i = 0; i < 60; i++) begin
            if (i == 0 || (second && i == 10)) begin
                cs_n = 1'b0; wr_n = 1'b0; a0 = 1'b1; din = 8'h00;
            end else begin
                cs_n = 1'b1; wr_n = 1'b1;
            end
            @(posedge clk); @(negedge clk);
            if (busy) busy_n++;
            if (dout[7]) dout7_n++;
            if (!busy && first_clr < 0) first_clr = i;
        end
        cs_n = 1'b1; wr_n = 1'b1;
    endtask

    task automatic test_busy;
        int bn, dn, fc;
        wr(0, 8'h12);
        busy_run(1'b0, bn, dn, fc);
`ifdef JT51_TIMER_REGS_BUSY_EN
        tests++;
        if (bn !== 32 || fc !== 32) begin
            fails++; $display("FAIL busy_single: cycles %0d clear@%0d required 32/32", bn, fc);
        end
        tests++;
        if (dn !== 32) begin
            fails++; $display("FAIL dout7_single: cycles %0d required 32", dn);
        end
        busy_run(1'b1, bn, dn, fc);
        tests++;
        if (bn !== 42 || fc !== 42) begin
            fails++; $display("FAIL busy_reload: cycles %0d clear@%0d required 42/42", bn, fc);
        end
        // cen gating: counter frozen while cen=0
        wr(1, 8'h00);
        cen = 1'b0;
        idle(50);
        tests++;
        if (busy !== 1'b1) begin
            fails++; $display("FAIL busy_cen_hold: got %b required 1", busy);
        end
        cen = 1'b1;
        idle(40);
        tests++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL busy_cen_release: got %b required 0", busy);
        end
        // address writes leave busy alone
        wr(0, 8'h12);
        tests++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL busy_addr_write: got %b required 0", busy);
        end
`else
        tests++;
        if (bn !== 0 || dn !== 0) begin
            fails++; $display("FAIL busy_disabled: busy %0d dout7 %0d required 0/0", bn, dn);
        end
`endif
    endtask

    task automatic test_held_strobe;
        int bn, fc;
        idle(40);
        wr(0, 8'h12);
        bn = 0; fc = -1;
        for (int i = 0; i < 40; i++) begin
            if (i < 5) begin
                cs_n = 1'b0; wr_n = 1'b0; a0 = 1'b1; din = (i == 0) ? 8'h55 : 8'h66;
            end else begin
                cs_n = 1'b1; wr_n = 1'b1;
            end
            @(posedge clk); @(negedge clk);
            if (busy) bn++;
            if (!busy && fc < 0) fc = i;
        end
        tests++;
        if (value_B !== 8'h55) begin
            fails++; $display("FAIL held_strobe_once: value_B %h required 55", value_B);
        end
`ifdef JT51_TIMER_REGS_BUSY_EN
        tests++;
        if (bn !== 32 || fc !== 32) begin
            fails++; $display("FAIL held_strobe_busy: cycles %0d clear@%0d required 32/32", bn, fc);
        end
`endif
    endtask

    task automatic keyon_run(output int n);
        n = 0;
        for (int i = 0; i < 25; i++) begin
            overflow_A = (i < 20);
            @(posedge clk); @(negedge clk);
            if (csm_keyon) n++;
        end
        overflow_A = 1'b0;
    endtask

    task automatic test_csm;
        int n;
        wr(0, 8'h14); wr(1, 8'h80);
        keyon_run(n);
        tests++;
        if (n !== 1) begin
            fails++; $display("FAIL csm_on: pulses %0d required 1", n);
        end
        wr(1, 8'h00);
        keyon_run(n);
        tests++;
        if (n !== 0) begin
            fails++; $display("FAIL csm_off: pulses %0d required 0", n);
        end
        // disabling write and overflow edge on the same clock: old csm_en wins
        wr(1, 8'h80);
        cs_n = 1'b0; wr_n = 1'b0; a0 = 1'b1; din = 8'h00; overflow_A = 1'b1;
        @(posedge clk); @(negedge clk);
        cs_n = 1'b1; wr_n = 1'b1;
        tests++;
        if (csm_keyon !== 1'b1) begin
            fails++; $display("FAIL csm_same_edge: got %b required 1", csm_keyon);
        end
        overflow_A = 1'b0;
        idle(2);
        overflow_A = 1'b1;
        @(posedge clk); @(negedge clk);
        tests++;
        if (csm_keyon !== 1'b0) begin
            fails++; $display("FAIL csm_after_disable: got %b required 0", csm_keyon);
        end
        overflow_A = 1'b0;
        idle(1);
    endtask

    task automatic test_mid_reset;
        wr(0, 8'h14); wr(1, 8'h01);
        flag_A = 1'b1;
        idle(2);
        rst = 1'b1;
        #1;
        tests++;
        if ({value_A, value_B, load_A, load_B, enable_irq_A, enable_irq_B,
             clr_flag_A, clr_flag_B, csm_keyon, busy, dout} !== 34'd0) begin
            fails++;
            $display("FAIL mid_reset: load_A=%b busy=%b dout=%h value_B=%h required 0",
                     load_A, busy, dout, value_B);
        end
        flag_A = 1'b0;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        wr(0, 8'h12); wr(1, 8'h77);
        tests++;
        if (value_B !== 8'h77 || value_A !== 10'd0 || load_A !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_write: value_B=%h value_A=%h load_A=%b required 77/000/0",
                     value_B, value_A, load_A);
        end
    endtask

    initial begin
        test_reset;
        test_value_regs;
        test_control;
        test_dout;
        test_busy;
        test_held_strobe;
        test_csm;
        test_mid_reset;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
